// File: rtl/pong_pkg.sv
// Shared pong definitions: rally FSM encoding, game defaults and paddle geometry.
// The velocity mapper uses PDL_HEIGHT too, so PDL_HALF_DEF follows it automatically.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_SERVE   = 2'd1,
        ST_PLAY    = 2'd2,
        ST_OVER    = 2'd3
    } state_e;

    localparam int WIN_SCORE_DEF    = 7;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int PDL_HEIGHT       = 96;
    localparam int PDL_HALF_DEF     = PDL_HEIGHT / 2;

    // Flag order is {game_startup, sq_missed, game_over}.
    function automatic logic [2:0] state_flags(input state_e s);
        return {s == ST_STARTUP, s == ST_SERVE, s == ST_OVER};
    endfunction

endpackage

// File: rtl/hit_offset.sv
// Distance from the paddle centre to the square, clamped to the paddle half-height,
// plus which side of the centre the square struck.
module hit_offset
    import pong_pkg::*;
#(
    parameter int PDL_HALF = PDL_HALF_DEF
) (
    input  logic [9:0] sq_y_i,
    input  logic [9:0] pdl_y_i,
    output logic [6:0] mag_o,
    output logic       below_o
);

    logic signed [10:0] diff;
    logic        [10:0] abs_diff;
    logic        [10:0] clamped;

    // The clamp is done at full width so large offsets never alias after truncation.
    always_comb begin
        diff     = $signed({1'b0, sq_y_i}) - $signed({1'b0, pdl_y_i});
        abs_diff = diff[10] ? $unsigned(-diff) : $unsigned(diff);
        clamped  = (abs_diff > 11'(PDL_HALF)) ? 11'(PDL_HALF) : abs_diff;
        mag_o    = 7'(clamped);
        below_o  = ~diff[10] & (diff != 11'sd0);
    end

endmodule

// File: rtl/rally_controller.sv
// Pong rally sequencer: start, serve delay, paddle hits, scoring and game over.
// Every output is a register updated by the single FSM process.
module rally_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int PDL_HALF     = PDL_HALF_DEF
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       hit_l,
    input  logic       hit_r,
    input  logic       out_l,
    input  logic       out_r,
    input  logic [9:0] sq_y,
    input  logic [9:0] pdl_l_y,
    input  logic [9:0] pdl_r_y,
    output logic       game_startup,
    output logic       sq_missed,
    output logic       game_over,
    output logic [6:0] hit_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       sq_launch
);

    state_e     state_q;
    logic [2:0] flags_q;
    logic       start_btn_q;
    logic [7:0] serve_cnt_q;
    logic [6:0] hit_y_q;
    logic       dir_x_q;
    logic       dir_y_q;
    logic [3:0] score_l_q;
    logic [3:0] score_r_q;
    logic       sq_launch_q;

    logic       start_evt;
    logic [9:0] pdl_sel;
    logic [6:0] hit_y_d;
    logic       dir_y_d;
    logic [3:0] score_l_d;
    logic [3:0] score_r_d;

    assign start_evt = start_btn & ~start_btn_q;
    assign pdl_sel   = hit_r ? pdl_r_y : pdl_l_y;

    // Saturating increments keep the score pinned at WIN_SCORE.
    assign score_l_d = (score_l_q >= 4'(WIN_SCORE)) ? score_l_q : score_l_q + 4'd1;
    assign score_r_d = (score_r_q >= 4'(WIN_SCORE)) ? score_r_q : score_r_q + 4'd1;

    hit_offset #(
        .PDL_HALF (PDL_HALF)
    ) u_hit_offset (
        .sq_y_i  (sq_y),
        .pdl_y_i (pdl_sel),
        .mag_o   (hit_y_d),
        .below_o (dir_y_d)
    );

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            state_q     <= ST_STARTUP;
            flags_q     <= state_flags(ST_STARTUP);
            start_btn_q <= 1'b0;
            serve_cnt_q <= 8'd0;
            hit_y_q     <= 7'd0;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            sq_launch_q <= 1'b0;
        end else begin
            start_btn_q <= start_btn;
            sq_launch_q <= 1'b0;
            unique case (state_q)
                ST_STARTUP: begin
                    if (start_evt) begin
                        state_q     <= ST_SERVE;
                        flags_q     <= state_flags(ST_SERVE);
                        score_l_q   <= 4'd0;
                        score_r_q   <= 4'd0;
                        dir_x_q     <= 1'b1;
                        serve_cnt_q <= 8'd0;
                        hit_y_q     <= 7'd0;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick) begin
                        if (serve_cnt_q == 8'(SERVE_FRAMES - 1)) begin
                            state_q     <= ST_PLAY;
                            flags_q     <= state_flags(ST_PLAY);
                            sq_launch_q <= 1'b1;
                        end else begin
                            serve_cnt_q <= serve_cnt_q + 8'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    // Outs beat hits, out_l beats out_r, and a double hit is treated as noise.
                    if (out_l) begin
                        score_r_q <= score_r_d;
                        dir_x_q   <= 1'b0;
                        if (score_r_d == 4'(WIN_SCORE)) begin
                            state_q <= ST_OVER;
                            flags_q <= state_flags(ST_OVER);
                        end else begin
                            state_q     <= ST_SERVE;
                            flags_q     <= state_flags(ST_SERVE);
                            serve_cnt_q <= 8'd0;
                            hit_y_q     <= 7'd0;
                        end
                    end else if (out_r) begin
                        score_l_q <= score_l_d;
                        dir_x_q   <= 1'b1;
                        if (score_l_d == 4'(WIN_SCORE)) begin
                            state_q <= ST_OVER;
                            flags_q <= state_flags(ST_OVER);
                        end else begin
                            state_q     <= ST_SERVE;
                            flags_q     <= state_flags(ST_SERVE);
                            serve_cnt_q <= 8'd0;
                            hit_y_q     <= 7'd0;
                        end
                    end else if (hit_l ^ hit_r) begin
                        hit_y_q <= hit_y_d;
                        dir_y_q <= dir_y_d;
                        dir_x_q <= hit_l;
                    end
                end
                ST_OVER: begin
                    if (start_evt) begin
                        state_q <= ST_STARTUP;
                        flags_q <= state_flags(ST_STARTUP);
                    end
                end
                default: begin
                    state_q <= ST_STARTUP;
                    flags_q <= state_flags(ST_STARTUP);
                end
            endcase
        end
    end

    assign {game_startup, sq_missed, game_over} = flags_q;
    assign hit_y     = hit_y_q;
    assign dir_x     = dir_x_q;
    assign dir_y     = dir_y_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign sq_launch = sq_launch_q;

endmodule

// File: tb/tb_rally_controller.sv
// Directed bench for rally_controller: serve timing, hit offsets, scoring,
// simultaneous-event priority and reset in the middle of a serve.
module tb_rally_controller;

    logic       clk_0 = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       hit_l = 1'b0;
    logic       hit_r = 1'b0;
    logic       out_l = 1'b0;
    logic       out_r = 1'b0;
    logic [9:0] sq_y = 10'd0;
    logic [9:0] pdl_l_y = 10'd0;
    logic [9:0] pdl_r_y = 10'd0;
    logic       game_startup;
    logic       sq_missed;
    logic       game_over;
    logic [6:0] hit_y;
    logic       dir_x;
    logic       dir_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       sq_launch;

    int total = 0;
    int bad = 0;

    localparam logic [4:0] P_FRAME = 5'b10000;
    localparam logic [4:0] P_HITL  = 5'b01000;
    localparam logic [4:0] P_HITR  = 5'b00100;
    localparam logic [4:0] P_OUTL  = 5'b00010;
    localparam logic [4:0] P_OUTR  = 5'b00001;

    rally_controller dut (
        .clk_0        (clk_0),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .start_btn    (start_btn),
        .hit_l        (hit_l),
        .hit_r        (hit_r),
        .out_l        (out_l),
        .out_r        (out_r),
        .sq_y         (sq_y),
        .pdl_l_y      (pdl_l_y),
        .pdl_r_y      (pdl_r_y),
        .game_startup (game_startup),
        .sq_missed    (sq_missed),
        .game_over    (game_over),
        .hit_y        (hit_y),
        .dir_x        (dir_x),
        .dir_y        (dir_y),
        .score_l      (score_l),
        .score_r      (score_r),
        .sq_launch    (sq_launch)
    );

    always #5 clk_0 = ~clk_0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    // Drive a one-cycle pulse on {frame_tick, hit_l, hit_r, out_l, out_r}.
    task automatic applyStimulus(input logic [4:0] p);
        {frame_tick, hit_l, hit_r, out_l, out_r} = p;
        tick();
        {frame_tick, hit_l, hit_r, out_l, out_r} = 5'b0;
    endtask

    task automatic pressStart();
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        tick();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".startup"}, game_startup, 1);
        checkOutput({tag, ".missed"}, sq_missed, 0);
        checkOutput({tag, ".over"}, game_over, 0);
        checkOutput({tag, ".hit_y"}, hit_y, 0);
        checkOutput({tag, ".dir_x"}, dir_x, 1);
        checkOutput({tag, ".dir_y"}, dir_y, 0);
        checkOutput({tag, ".score_l"}, score_l, 0);
        checkOutput({tag, ".score_r"}, score_r, 0);
        checkOutput({tag, ".launch"}, sq_launch, 0);
    endtask

    task automatic serveToPlay(input string tag);
        for (int i = 0; i < 59; i++) begin
            applyStimulus(P_FRAME);
            tick();
        end
        checkOutput({tag, ".still_serve"}, sq_missed, 1);
        checkOutput({tag, ".no_launch_yet"}, sq_launch, 0);
        applyStimulus(P_FRAME);
        checkOutput({tag, ".launch"}, sq_launch, 1);
        checkOutput({tag, ".missed_low"}, sq_missed, 0);
        tick();
        checkOutput({tag, ".launch_once"}, sq_launch, 0);
    endtask

    initial begin
        rst = 1'b0;
        tick();
        tick();
        checkResetValues("reset");

        rst = 1'b1;
        tick();
        checkOutput("idle.startup", game_startup, 1);
        pressStart();
        checkOutput("start.startup", game_startup, 0);
        checkOutput("start.missed", sq_missed, 1);
        serveToPlay("serve1");

        pdl_l_y = 10'd200;
        pdl_r_y = 10'd300;
        sq_y = 10'd230;
        applyStimulus(P_HITL);
        checkOutput("hitl230.hit_y", hit_y, 30);
        checkOutput("hitl230.dir_y", dir_y, 1);
        checkOutput("hitl230.dir_x", dir_x, 1);
        sq_y = 10'd100;
        applyStimulus(P_HITL);
        checkOutput("hitl100.hit_y", hit_y, 48);
        checkOutput("hitl100.dir_y", dir_y, 0);
        sq_y = 10'd200;
        applyStimulus(P_HITL);
        checkOutput("hitl_eq.hit_y", hit_y, 0);
        checkOutput("hitl_eq.dir_y", dir_y, 0);
        sq_y = 10'd290;
        applyStimulus(P_HITR);
        checkOutput("hitr290.hit_y", hit_y, 10);
        checkOutput("hitr290.dir_y", dir_y, 0);
        checkOutput("hitr290.dir_x", dir_x, 0);
        sq_y = 10'd230;
        applyStimulus(P_HITL | P_HITR);
        checkOutput("hit_both.hit_y", hit_y, 10);
        checkOutput("hit_both.dir_x", dir_x, 0);
        checkOutput("hit_both.dir_y", dir_y, 0);

        applyStimulus(P_OUTR);
        checkOutput("outr.score_l", score_l, 1);
        checkOutput("outr.score_r", score_r, 0);
        checkOutput("outr.missed", sq_missed, 1);
        checkOutput("outr.hit_y", hit_y, 0);
        checkOutput("outr.dir_x", dir_x, 1);
        applyStimulus(P_HITL);
        checkOutput("hit_in_serve.hit_y", hit_y, 0);

        serveToPlay("serve2");
        applyStimulus(P_OUTL | P_OUTR);
        checkOutput("out_both.score_r", score_r, 1);
        checkOutput("out_both.score_l", score_l, 1);
        checkOutput("out_both.dir_x", dir_x, 0);

        serveToPlay("serve3");
        sq_y = 10'd290;
        applyStimulus(P_HITR | P_OUTL);
        checkOutput("hitr_outl.hit_y", hit_y, 0);
        checkOutput("hitr_outl.score_r", score_r, 2);
        checkOutput("hitr_outl.dir_x", dir_x, 0);
        checkOutput("hitr_outl.missed", sq_missed, 1);

        for (int k = 0; k < 5; k++) begin
            serveToPlay("serve_loop");
            applyStimulus(P_OUTR);
        end
        checkOutput("six.score_l", score_l, 6);
        checkOutput("six.over", game_over, 0);
        serveToPlay("serve_last");
        applyStimulus(P_OUTR);
        checkOutput("win.score_l", score_l, 7);
        checkOutput("win.over", game_over, 1);
        checkOutput("win.missed", sq_missed, 0);
        applyStimulus(P_OUTR);
        applyStimulus(P_OUTL);
        applyStimulus(P_FRAME);
        checkOutput("over_hold.score_l", score_l, 7);
        checkOutput("over_hold.score_r", score_r, 2);
        checkOutput("over_hold.over", game_over, 1);

        pressStart();
        checkOutput("restart.startup", game_startup, 1);
        checkOutput("restart.over", game_over, 0);
        checkOutput("restart.score_l_held", score_l, 7);
        pressStart();
        checkOutput("newgame.missed", sq_missed, 1);
        checkOutput("newgame.score_l", score_l, 0);
        checkOutput("newgame.score_r", score_r, 0);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(P_FRAME);
        end
        checkOutput("mid_serve.missed", sq_missed, 1);
        rst = 1'b0;
        start_btn = 1'b0;
        tick();
        checkResetValues("reset_mid");
        rst = 1'b1;
        tick();
        pressStart();
        checkOutput("after_reset.missed", sq_missed, 1);
        serveToPlay("serve_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
